// File: rtl/vga_timing_gen.sv
// Raster timing generator: hcnt/vcnt counters, sync pulses, active-video flag,
// line/frame strobes and a frame counter, advancing on a pixel enable.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          pclk,
  input  logic          resetn,
  input  logic          ce,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic [7:0]    fcnt_q, fcnt_d;

  // Levels are decoded from the next-state counts so they line up with the
  // registered counters in the same cycle.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    active_d = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
    hsync_d  = ((hcnt_d >= HS_FIRST) && (hcnt_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vsync_d  = ((vcnt_d >= VS_FIRST) && (vcnt_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    // Strobes need ce so that idling at (0,0) does not re-fire them.
    ls_d     = ce && (hcnt_d == '0);
    fs_d     = ls_d && (vcnt_d == '0);
    fcnt_d   = fcnt_q + {7'd0, fs_d};
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      hcnt_q   <= H_LAST;
      vcnt_q   <= V_LAST;
      active_q <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      fcnt_q   <= 8'd0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x10 raster, with a second
// instance using active-high sync polarity.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int CW = 5;
  localparam int HT = HA + HF + HS + HB;  // 16
  localparam int VT = VA + VF + VS + VB;  // 10

  logic          pclk = 1'b0;
  logic          resetn, ce;
  logic [CW-1:0] hcnt, vcnt, hcnt_p, vcnt_p;
  logic          active, hsync, vsync, ls, fs;
  logic          active_p, hsync_p, vsync_p, ls_p, fs_p;
  logic [7:0]    fcnt, fcnt_p;

  int ntests = 0;
  int nfail  = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)) dut (
    .pclk(pclk), .resetn(resetn), .ce(ce), .hcnt(hcnt), .vcnt(vcnt),
    .active(active), .hsync(hsync), .vsync(vsync), .line_start(ls),
    .frame_start(fs), .frame_cnt(fcnt));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)) dut_p (
    .pclk(pclk), .resetn(resetn), .ce(ce), .hcnt(hcnt_p), .vcnt(vcnt_p),
    .active(active_p), .hsync(hsync_p), .vsync(vsync_p), .line_start(ls_p),
    .frame_start(fs_p), .frame_cnt(fcnt_p));

  typedef struct {
    bit ce;
    int h, v;
    bit act, hs, vs, ls, fs;
    int fc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  // Advance until frame_start, optionally toggling ce; n = edges taken.
  task automatic wait_fs(input int lim, input bit tog, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < lim && !ok) begin
      if (tog) ce = ~ce;
      tick();
      n++;
      if (fs) ok = 1'b1;
    end
  endtask

  initial begin
    vec_t vt[6];
    int   n, lows, bad, lsa, lsb, vlow;
    bit   ok;

    vt[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vt[1] = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[2] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[3] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[4] = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vt[5] = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};

    resetn = 1'b0;
    ce     = 1'b0;
    #12;
    chk("rst_hcnt", int'(hcnt), HT - 1);
    chk("rst_vcnt", int'(vcnt), VT - 1);
    chk("rst_active", int'(active), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_strobes", int'({ls, fs}), 0);
    chk("rst_fcnt", int'(fcnt), 0);
    chk("rst_hsync_pos", int'(hsync_p), 0);
    chk("rst_vsync_pos", int'(vsync_p), 0);
    #1 resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      ce = vt[i].ce;
      tick();
      chk($sformatf("v%0d_hcnt", i), int'(hcnt), vt[i].h);
      chk($sformatf("v%0d_vcnt", i), int'(vcnt), vt[i].v);
      chk($sformatf("v%0d_active", i), int'(active), int'(vt[i].act));
      chk($sformatf("v%0d_hsync", i), int'(hsync), int'(vt[i].hs));
      chk($sformatf("v%0d_vsync", i), int'(vsync), int'(vt[i].vs));
      chk($sformatf("v%0d_ls", i), int'(ls), int'(vt[i].ls));
      chk($sformatf("v%0d_fs", i), int'(fs), int'(vt[i].fs));
      chk($sformatf("v%0d_fcnt", i), int'(fcnt), vt[i].fc);
    end

    // Two lines from h=3,v=0: sync window, active edge, line period.
    ce = 1'b1; lows = 0; bad = 0; lsa = -1; lsb = -1;
    for (int k = 1; k <= 2 * HT; k++) begin
      tick();
      if (k <= HT && !hsync) lows++;
      if ((!hsync) != (hcnt >= 10 && hcnt <= 12)) bad++;
      if (hsync_p != (hcnt >= 10 && hcnt <= 12)) bad++;
      if (active != (hcnt < 8)) bad++;
      if (ls && lsa < 0) lsa = k;
      else if (ls && lsb < 0) lsb = k;
    end
    chk("line_hsync_width", lows, HS);
    chk("line_decode_errs", bad, 0);
    chk("line_ls_period", lsb - lsa, HT);

    // Full frame: wrap into (0,0), vsync width, frame period.
    wait_fs(4 * HT * VT, 1'b0, n, ok);
    chk("frame_first_found", int'(ok), 1);
    chk("frame_wrap_h", int'(hcnt), 0);
    chk("frame_wrap_v", int'(vcnt), 0);
    n = 0; vlow = 0; bad = 0; ok = 1'b0;
    while (n < 2 * HT * VT && !ok) begin
      tick();
      n++;
      if (!vsync) vlow++;
      if ((!vsync) != (vcnt == 7 || vcnt == 8)) bad++;
      if (vsync_p != (vcnt == 7 || vcnt == 8)) bad++;
      if (hcnt == HT - 1 && vcnt == VT - 1) begin
        tick();
        n++;
        chk("frame_after_last_fs", int'(fs), 1);
        chk("frame_after_last_hv", int'({hcnt, vcnt}), 0);
        ok = 1'b1;
      end
    end
    chk("frame_period", n, HT * VT);
    chk("frame_vsync_width", vlow, VS * HT);
    chk("frame_vsync_errs", bad, 0);

    // ce toggling: step every second pclk, strobes stay one pclk.
    ce = 1'b0;
    wait_fs(8 * HT * VT, 1'b1, n, ok);
    chk("tog_sync_found", int'(ok), 1);
    ce = 1'b0;
    tick();
    chk("tog_fs_width", int'(fs), 0);
    chk("tog_ls_width", int'(ls), 0);
    chk("tog_hold_h", int'(hcnt), 0);
    wait_fs(8 * HT * VT, 1'b1, n, ok);
    chk("tog_found", int'(ok), 1);
    chk("tog_period", n + 1, 2 * HT * VT);

    // Async reset mid-frame at (5,4).
    ce = 1'b1; n = 0;
    while (n < 2 * HT * VT && !(hcnt == 5 && vcnt == 4)) begin
      tick();
      n++;
    end
    chk("mid_reached", int'(hcnt == 5 && vcnt == 4), 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_hcnt", int'(hcnt), HT - 1);
    chk("mid_rst_vcnt", int'(vcnt), VT - 1);
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_fcnt", int'(fcnt), 0);
    chk("mid_rst_hsync_pos", int'(hsync_p), 0);
    #3 resetn = 1'b1;
    tick();
    chk("mid_restart_hv", int'({hcnt, vcnt}), 0);
    chk("mid_restart_fs", int'(fs), 1);
    chk("mid_restart_fcnt", int'(fcnt), 1);

    // frame_cnt wraps 255 -> 0 on the 256th frame_start.
    bad = 0;
    for (int f = 1; f <= 255; f++) begin
      wait_fs(2 * HT * VT, 1'b0, n, ok);
      if (!ok) begin
        chk("wrap_timeout", f, -1);
        break;
      end
      if (int'(fcnt) != ((1 + f) % 256)) bad++;
    end
    chk("wrap_fcnt_errs", bad, 0);
    chk("wrap_fcnt_final", int'(fcnt), 0);
    chk("wrap_fcnt_pos", int'(fcnt_p), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the pmod VGA pixel generator: produces raster counters, sync pulses, active-video flag and frame/line strobes from a single pixel clock.
- The downstream pixel/text renderer consumes hcnt/vcnt/active and forwards hsync/vsync to the pmod pins.
- Timing is fully parameterised; defaults are 640x480@60 (800x525 total).
- Advances only on a pixel-enable, so it can also run from a faster fabric clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync (0 = active-low)
VS_POL, 0, asserted level of vsync (0 = active-low)
CW, 11, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
pclk  in  1  pixel clock; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
ce  in  1  pixel enable; counters advance only when high
hcnt  out  CW  current horizontal position, 0..H_TOTAL-1
vcnt  out  CW  current line, 0..V_TOTAL-1
active  out  1  high when hcnt<H_ACTIVE and vcnt<V_ACTIVE
hsync  out  1  horizontal sync at HS_POL level when asserted
vsync  out  1  vertical sync at VS_POL level when asserted
line_start  out  1  one-pclk strobe when hcnt becomes 0
frame_start  out  1  one-pclk strobe when (hcnt,vcnt) becomes (0,0)
frame_cnt  out  8  frames started since reset, wraps 255->0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is pclk, reset port is resetn.
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values: hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, active=0, hsync=!HS_POL, vsync=!VS_POL, line_start=0, frame_start=0, frame_cnt=0.
  - Effect: the first ce after reset loads (0,0) and raises frame_start and line_start.
- Counter step (rising pclk with ce=1):
  - hcnt<H_TOTAL-1: hcnt+1.
  - Otherwise: hcnt=0 and vcnt steps; vcnt wraps V_TOTAL-1 -> 0.
  - ce=0: all counters and levels hold; strobes go low.
- All outputs are registered. active/hsync/vsync always describe the hcnt/vcnt values presented in the same cycle (zero skew); implement by decoding next-state counts.
- hsync asserted iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync asserted iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line, independent of hcnt.
- Strobes:
  - line_start is high exactly one pclk, in the cycle whose registered hcnt is newly 0.
  - frame_start is likewise high one pclk when (0,0) is newly loaded.
  - If ce is held low while at (0,0), strobes do not repeat.
- frame_cnt increments in the same cycle frame_start is asserted; modulo-256.
- ce continuously high gives line period H_TOTAL pclks and frame period H_TOTAL*V_TOTAL (420000) pclks.
- resetn asserted mid-frame: outputs take reset values immediately (asynchronously). Release is synchronous to pclk; the next ce restarts at (0,0).
- No illegal states: counters never exceed TOTAL-1. The default CW covers the defaults.

Test Plan:
- Reset release, ce=1 constant -> first cycle hcnt=0, vcnt=0, active=1, frame_start=1, line_start=1, frame_cnt=1; the next cycle both strobes are 0.
- Run one line -> hsync low for exactly hcnt 656..751 (96 pclks); active falls when hcnt=640; line_start period 800 pclks.
- Run full frame -> vsync low for vcnt 490..491 (1600 pclks); after hcnt=799,vcnt=524 the next is (0,0) with frame_start; frame period 420000 pclks.
- ce toggling 1/0 every cycle -> counters step every second pclk; strobes are one pclk wide; frame period 840000 pclks.
- Assert resetn low at hcnt=300, vcnt=200 -> outputs go to reset values without a clock edge; after release the first ce gives (0,0) and frame_start.
- Run 256 frames -> frame_cnt wraps 255->0 on the 256th frame_start.
- Set HS_POL=1, VS_POL=1 -> sync pulses inverted at the same positions; idle level 0, including during reset.
